// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8
// Receive end of an 8-slot, 1-bit-per-slot TDM link. A frame-sync strobe that
// arrives with the slot-0 bit sets the frame alignment. Each serial bit goes to
// its channel position, and every complete frame is delivered as one 8-bit word
// while the receiver is locked. A HUNT/CHECK/LOCKED supervisor qualifies the
// alignment before any data is delivered. It also flywheels over a limited
// number of missing sync pulses before it declares loss of sync.
module tdm_demux_1x8 #(
  parameter int LOCK_CNT = 2,  // consecutive aligned fsyncs after detection to lock (1..7)
  parameter int MISS_MAX = 3   // consecutive missing fsyncs that drop lock (1..7)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  input  logic       fsync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_CNT_C = 3'(LOCK_CNT);
  localparam logic [2:0] MISS_MAX_C = 3'(MISS_MAX);

  state_t     r_state,      w_state_nxt;
  logic [2:0] r_slot,       w_slot_nxt;
  logic [2:0] r_good,       w_good_nxt;
  logic [2:0] r_miss,       w_miss_nxt;
  logic [7:0] r_shadow,     w_shadow_nxt;
  logic [7:0] r_dout,       w_dout_nxt;
  logic       r_dout_valid, w_dout_valid_nxt;
  logic       r_sync_err,   w_sync_err_nxt;

  logic [2:0] w_good_inc;
  logic [2:0] w_miss_inc;
  logic [2:0] w_wr_idx;

  assign w_good_inc = r_good + 3'd1;
  assign w_miss_inc = r_miss + 3'd1;
  // A realigning fsync always marks the bit as slot 0 of a new frame.
  assign w_wr_idx   = fsync ? 3'd0 : r_slot;

  // Register all state and the registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_slot       <= 3'd0;
      r_good       <= 3'd0;
      r_miss       <= 3'd0;
      // NOTE: the shadow register is reset even though it is data storage.
      // This keeps a partial frame from an earlier alignment from being
      // observable after a reset.
      r_shadow     <= 8'd0;
      r_dout       <= 8'd0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from
      // pre-edge values, so the order of statements here does not matter.
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_good       <= w_good_nxt;
      r_miss       <= w_miss_nxt;
      r_shadow     <= w_shadow_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_sync_err   <= w_sync_err_nxt;
    end
  end

  // Compute the next state: alignment supervision, slot counting, bit capture
  // and frame delivery.
  always_comb begin
    // NOTE: every output of this block gets a default value before any branch.
    // Without the defaults, a path that skips an assignment would infer a latch.
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_good_nxt       = r_good;
    w_miss_nxt       = r_miss;
    w_shadow_nxt     = r_shadow;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;

    if (en) begin
      if (r_state == ST_HUNT) begin
        // While hunting, slot stays at 0. Only a sync pulse moves us on.
        if (fsync) begin
          w_state_nxt     = ST_CHECK;
          w_slot_nxt      = 3'd1;
          w_good_nxt      = 3'd0;
          w_shadow_nxt[0] = din;
        end
      end else begin
        // Aligned states capture every bit and keep counting slots.
        w_shadow_nxt[w_wr_idx] = din;
        w_slot_nxt             = fsync ? 3'd1 : (r_slot + 3'd1);

        unique case (r_state)
          ST_CHECK: begin
            if (r_slot == 3'd0) begin
              if (fsync) begin
                w_good_nxt = w_good_inc;
                if (w_good_inc == LOCK_CNT_C) begin
                  w_state_nxt = ST_LOCKED;
                  w_miss_nxt  = 3'd0;
                end
              end else begin
                // The expected sync did not appear, so the alignment was false.
                w_state_nxt = ST_HUNT;
                w_slot_nxt  = 3'd0;
              end
            end else if (fsync) begin
              // The sync came early: restart qualification from this point.
              w_good_nxt = 3'd0;
            end
          end

          ST_LOCKED: begin
            if (r_slot == 3'd0) begin
              if (fsync) begin
                w_miss_nxt = 3'd0;
              end else if (w_miss_inc == MISS_MAX_C) begin
                // Too many consecutive missing syncs: give up this alignment.
                w_state_nxt    = ST_HUNT;
                w_slot_nxt     = 3'd0;
                w_sync_err_nxt = 1'b1;
              end else begin
                // Flywheel: count the miss and keep delivering frames.
                w_miss_nxt = w_miss_inc;
              end
            end else if (fsync) begin
              // A misplaced sync drops the partial frame and requalifies.
              w_state_nxt    = ST_CHECK;
              w_good_nxt     = 3'd0;
              w_sync_err_nxt = 1'b1;
            end else if (r_slot == 3'd7) begin
              w_dout_nxt       = {din, r_shadow[6:0]};
              w_dout_valid_nxt = 1'b1;
            end
          end

          default: begin
            w_state_nxt = ST_HUNT;
            w_slot_nxt  = 3'd0;
          end
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == ST_LOCKED);
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8
// Self-checking bench for the TDM demux. A frame-level reference model predicts
// every output after every clock. Directed scenarios cover lock, sparse strobe,
// flywheel, misplaced sync, reset and a CHECK failure. A randomized phase
// follows the directed scenarios.
module tb_tdm_demux_1x8;

  localparam int LOCK_CNT = 2;
  localparam int MISS_MAX = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       fsync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  tdm_demux_1x8 #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_mism = 0;
  int cycle  = 0;

  // Observed pulse tallies, used for scenario-level expectations.
  int       n_valid = 0;
  int       n_serr  = 0;
  bit [7:0] last_dout = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mism++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  localparam int M_HUNT = 0, M_CHECK = 1, M_LOCK = 2;
  int       m_mode = M_HUNT;
  int       m_pos  = 0;      // position of the next bit within the frame
  int       m_good = 0;      // aligned syncs seen since first detection
  int       m_miss = 0;      // consecutive syncs missing while locked
  bit [7:0] m_bits = 8'd0;   // frame being assembled
  bit [7:0] m_dout = 8'd0;
  bit       m_valid = 1'b0;
  bit       m_err   = 1'b0;

  task automatic model_step(input bit r, input bit e, input bit d, input bit fs);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      m_mode = M_HUNT; m_pos = 0; m_good = 0; m_miss = 0;
      m_bits = 8'd0;   m_dout = 8'd0;
      return;
    end
    if (!e) return;
    if (m_mode == M_HUNT) begin
      if (fs) begin
        m_bits[0] = d; m_mode = M_CHECK; m_pos = 1; m_good = 0;
      end
      return;
    end
    if (fs) begin
      // A sync pulse always starts a new frame here.
      m_bits[0] = d;
      if (m_pos == 0) begin
        if (m_mode == M_CHECK) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_mode = M_LOCK; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end else begin
        if (m_mode == M_LOCK) m_err = 1'b1;
        m_mode = M_CHECK; m_good = 0;
      end
      m_pos = 1;
      return;
    end
    m_bits[m_pos] = d;
    if (m_pos == 0 && m_mode == M_CHECK) begin
      m_mode = M_HUNT; m_pos = 0;
      return;
    end
    if (m_pos == 0 && m_mode == M_LOCK) begin
      m_miss++;
      if (m_miss == MISS_MAX) begin
        m_mode = M_HUNT; m_pos = 0; m_err = 1'b1;
        return;
      end
    end
    if (m_pos == 7 && m_mode == M_LOCK) begin
      m_dout  = m_bits;
      m_valid = 1'b1;
    end
    m_pos = (m_pos + 1) % 8;
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge.
  task automatic step(input bit r, input bit e, input bit d, input bit fs);
    rst_n = r; en = e; din = d; fsync = fs;
    @(posedge clk);
    model_step(r, e, d, fs);
    cycle++;
    #1;
    check("dout",       32'(dout),       32'(m_dout));
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("slot",       32'(slot),       32'(m_pos));
    check("locked",     32'(locked),     32'(m_mode == M_LOCK));
    check("sync_err",   32'(sync_err),   32'(m_err));
    if (dout_valid) begin
      n_valid++;
      last_dout = dout;
    end
    if (sync_err) n_serr++;
  endtask

  // Send bits lo..hi of a payload (bit0 first). fsync rides on bit index fs_bit
  // (-1 for none). gap idle (en=0) cycles with junk inputs follow each bit.
  task automatic send_range(input bit [7:0] p, input int lo, input int hi,
                            input int fs_bit, input int gap);
    for (int i = lo; i <= hi; i++) begin
      step(1'b1, 1'b1, p[i], (i == fs_bit));
      for (int g = 0; g < gap; g++)
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic send_frame(input bit [7:0] p, input bit with_fs, input int gap);
    send_range(p, 0, 7, with_fs ? 0 : -1, gap);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // Lock acquisition with payloads 0x11, 0x22, 0xA5 at a given strobe spacing.
  task automatic lock_scenario(input string name, input int gap);
    int v0;
    v0 = n_valid;
    send_frame(8'h11, 1'b1, gap);
    send_frame(8'h22, 1'b1, gap);
    check({name, "_locked_before"}, 32'(locked), 32'd0);
    send_range(8'hA5, 0, 0, 0, 0);
    check({name, "_locked_rise"}, 32'(locked), 32'd1);
    for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    send_range(8'hA5, 1, 7, -1, gap);
    check({name, "_valid_cnt"}, 32'(n_valid - v0), 32'd1);
    check({name, "_dout"},      32'(last_dout),   32'hA5);
  endtask

  initial begin
    int v0, e0;
    int tx;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; fsync = 1'b0;

    // Reset state.
    do_reset();
    check("rst_dout",  32'(dout),   32'd0);
    check("rst_slot",  32'(slot),   32'd0);
    check("rst_locked",32'(locked), 32'd0);

    // Lock acquisition, dense and sparse strobe.
    lock_scenario("lock", 0);
    do_reset();
    lock_scenario("sparse", 2);

    // Flywheel: two missing syncs are tolerated, the third drops lock.
    v0 = n_valid; e0 = n_serr;
    send_frame(8'h3C, 1'b0, 0);
    check("fly1_dout", 32'(last_dout), 32'h3C);
    send_frame(8'hC3, 1'b0, 0);
    check("fly2_dout", 32'(last_dout), 32'hC3);
    check("fly_locked", 32'(locked), 32'd1);
    send_frame(8'h77, 1'b0, 0);
    check("fly_valid_cnt", 32'(n_valid - v0), 32'd2);
    check("fly_serr_cnt",  32'(n_serr - e0),  32'd1);
    check("fly_unlocked",  32'(locked), 32'd0);
    check("fly_hold_dout", 32'(dout),   32'hC3);

    // Misplaced sync while locked, then relock.
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    check("mis_pre_locked", 32'(locked), 32'd1);
    v0 = n_valid; e0 = n_serr;
    send_range(8'h96, 0, 3, 0, 0);
    send_range(8'h4B, 0, 0, 0, 0);          // sync lands on slot 4
    check("mis_serr_cnt", 32'(n_serr - e0), 32'd1);
    check("mis_slot",     32'(slot),   32'd1);
    check("mis_unlocked", 32'(locked), 32'd0);
    send_range(8'h4B, 1, 7, -1, 0);
    check("mis_no_valid", 32'(n_valid - v0), 32'd0);
    send_frame(8'h5A, 1'b1, 0);
    send_frame(8'hE1, 1'b1, 0);
    check("mis_relocked", 32'(locked), 32'd1);
    check("mis_relock_dout", 32'(last_dout), 32'hE1);

    // Reset mid-frame at slot 5 of a locked frame.
    v0 = n_valid;
    send_range(8'hE7, 0, 4, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("mrst_dout",   32'(dout),   32'd0);
    check("mrst_slot",   32'(slot),   32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    send_range(8'hE7, 6, 7, -1, 0);
    check("mrst_no_valid", 32'(n_valid - v0), 32'd0);

    // CHECK failure: one sync, then a frame without it.
    v0 = n_valid;
    send_frame(8'h99, 1'b1, 0);
    send_frame(8'h66, 1'b0, 0);
    send_frame(8'h55, 1'b0, 0);
    check("chk_slot",     32'(slot),   32'd0);
    check("chk_locked",   32'(locked), 32'd0);
    check("chk_no_valid", 32'(n_valid - v0), 32'd0);

    // Randomized traffic: mostly well-formed frames with dropped and
    // spurious syncs, gaps in the strobe, and occasional resets.
    tx = 0;
    for (int c = 0; c < 4000; c++) begin
      bit r, e, d, fs;
      r  = ($urandom_range(0, 399) != 0);
      e  = ($urandom_range(0, 9) < 7);
      d  = 1'($urandom);
      fs = 1'b0;
      if (e) begin
        if (tx == 0) fs = ($urandom_range(0, 19) != 0);
        else         fs = ($urandom_range(0, 99) == 0);
        tx = fs ? 1 : (tx + 1) % 8;
      end
      step(r, e, d, fs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
